// File: rtl/instr_pkg.sv
// Instruction word layout and encoder state type, shared with the decode stage.
package instr_pkg;

  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned COND_MSB = 15;
  localparam int unsigned OP_MSB   = 13;
  localparam int unsigned DEST_MSB = 9;
  localparam int unsigned SRC1_MSB = 6;
  localparam int unsigned SRC2_MSB = 3;
  localparam int unsigned SHIFT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } enc_state_t;

  function automatic logic [INSTR_W-1:0] encode_instr(
    input logic [1:0]         cond,
    input logic [3:0]         op,
    input logic [2:0]         dest,
    input logic [2:0]         src1,
    input logic [2:0]         src2,
    input logic               is_shift,
    input logic [SHIFT_W-1:0] shamt
  );
    logic [INSTR_W-1:0] w;
    w = '0;
    w[COND_MSB -: 2] = cond;
    w[OP_MSB -: 4]   = op;
    w[DEST_MSB -: 3] = dest;
    w[SRC1_MSB -: 3] = src1;
    // Shift form reuses the src2 field and the low pad bit for the amount.
    if (is_shift) w[SRC2_MSB -: SHIFT_W] = shamt;
    else          w[SRC2_MSB -: 3]       = src2;
    return w;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Decoded-field tuple handshake into the instruction encoder.
interface instruction_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic [1:0] condition;
  logic [3:0] op_code;
  logic [2:0] dest_reg;
  logic [2:0] source_reg_one;
  logic [2:0] source_reg_two;
  logic       is_shift;
  logic [3:0] bits_to_shift;

  modport master (
    output in_valid, in_last, condition, op_code, dest_reg,
           source_reg_one, source_reg_two, is_shift, bits_to_shift,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, condition, op_code, dest_reg,
           source_reg_one, source_reg_two, is_shift, bits_to_shift,
    output in_ready
  );
endinterface

// File: rtl/instruction_encoder_fifo.sv
// Synchronous FIFO with flush; head data is read combinationally.
module instr_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs decoded instruction fields into raw words and streams them into
// instruction memory at consecutive addresses.
module instruction_encoder
  import instr_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  instruction_encoder_if.slave in_if,
  output logic                 mem_we,
  input  logic                 mem_ready,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [INSTR_W-1:0]   mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      count,
  output logic                 overflow
);

  enc_state_t         state;
  enc_state_t         state_nxt;
  logic               ready;
  logic               accept;
  logic               restart;
  logic               wr_fire;
  logic               fifo_full;
  logic               fifo_empty;
  logic [INSTR_W-1:0] enc_word;
  logic [INSTR_W-1:0] fifo_head;

  assign enc_word = encode_instr(in_if.condition, in_if.op_code, in_if.dest_reg,
                                 in_if.source_reg_one, in_if.source_reg_two,
                                 in_if.is_shift, in_if.bits_to_shift);

  // start is honoured everywhere except DONE; in IDLE the FIFO is already empty.
  assign restart        = start && (state != ST_DONE);
  assign accept         = in_if.in_valid && ready;
  assign wr_fire        = mem_we && mem_ready;
  assign in_if.in_ready = ready;
  assign mem_we         = !fifo_empty;
  assign mem_wdata      = fifo_empty ? '0 : fifo_head;
  assign busy           = (state != ST_IDLE);

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (wr_fire),
    .flush (restart),
    .wdata (enc_word),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        ready = !fifo_full;
        if (start)                      state_nxt = ST_RUN;
        else if (accept && in_if.in_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (start)           state_nxt = ST_RUN;
        else if (fifo_empty) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (restart) begin
      mem_addr <= base_addr;
      count    <= '0;
      overflow <= 1'b0;
    end else if (wr_fire) begin
      mem_addr <= mem_addr + 1'b1;
      if (mem_addr == '1) overflow <= 1'b1;
      if (count != '1)    count    <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder.
`timescale 1ns/1ps
module tb_instruction_encoder;
  import instr_pkg::*;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned ADDR_SPAN = 1 << ADDR_W;
  localparam int unsigned COUNT_MAX = (1 << (ADDR_W + 1)) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              mem_we;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [ADDR_W:0]   count;

  instruction_encoder_if bus ();

  instruction_encoder #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .in_if     (bus),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: queue of expected words, next address, counters.
  int unsigned exp_q[$];
  int unsigned m_addr, m_count, m_dcnt;
  bit          m_ovf, m_running, m_draining, m_done;
  int unsigned cyc = 0;
  bit          t_hs, t_wr;
  int unsigned t_wa, t_wd, e_wa, e_wd;

  function automatic int unsigned ref_word(int unsigned c, int unsigned o, int unsigned d,
                                           int unsigned s1, int unsigned s2,
                                           bit sh, int unsigned amt);
    return c * 16384 + o * 1024 + d * 128 + s1 * 16 + (sh ? amt : s2 * 2);
  endfunction

  task automatic model_init();
    exp_q.delete();
    m_addr = 0; m_count = 0; m_dcnt = 0;
    m_ovf = 0; m_running = 0; m_draining = 0; m_done = 0;
  endtask

  // Advance one clock, recording handshake/write events and updating the model.
  task automatic tick();
    bit          st_eff;
    int unsigned w;
    t_hs   = bus.in_valid && bus.in_ready;
    t_wr   = mem_we && mem_ready;
    t_wa   = 32'(mem_addr);
    t_wd   = 32'(mem_wdata);
    e_wa   = m_addr;
    e_wd   = (exp_q.size() > 0) ? exp_q[0] : 0;
    st_eff = start && !m_done;
    w = ref_word(bus.condition, bus.op_code, bus.dest_reg, bus.source_reg_one,
                 bus.source_reg_two, bus.is_shift, bus.bits_to_shift);
    @(posedge clk);
    #1;
    cyc++;
    m_done = 0;
    if (st_eff) begin
      exp_q.delete();
      m_addr = 32'(base_addr); m_count = 0; m_ovf = 0;
      m_running = 1; m_draining = 0; m_dcnt = 0;
      t_hs = 0; t_wr = 0;
    end else begin
      if (t_wr && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (m_addr == ADDR_SPAN - 1) m_ovf = 1;
        m_addr = (m_addr + 1) % ADDR_SPAN;
        if (m_count < COUNT_MAX) m_count++;
      end
      if (t_hs) begin
        exp_q.push_back(w);
        if (bus.in_last) begin
          m_running = 0;
          m_draining = 1;
        end
      end
      if (m_draining && exp_q.size() == 0) begin
        m_dcnt++;
        if (m_dcnt == 2) begin
          m_done = 1; m_draining = 0; m_dcnt = 0;
        end
      end
    end
  endtask

  task automatic set_tuple(input int unsigned c, input int unsigned o, input int unsigned d,
                           input int unsigned s1, input int unsigned s2,
                           input bit sh, input int unsigned amt, input bit last);
    bus.condition      = 2'(c);
    bus.op_code        = 4'(o);
    bus.dest_reg       = 3'(d);
    bus.source_reg_one = 3'(s1);
    bus.source_reg_two = 3'(s2);
    bus.is_shift       = sh;
    bus.bits_to_shift  = 4'(amt);
    bus.in_last        = last;
    bus.in_valid       = 1'b1;
  endtask

  task automatic set_tuple_random(input bit last);
    set_tuple($urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom), $urandom, last);
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base);
    if (m_done) tick();
    bus.in_valid = 1'b0;
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_last = 0;
    set_tuple(0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 0;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.in_ready, mem_we, busy, done, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got ready/we/busy/done/ovf=%b expected 00000",
               {bus.in_ready, mem_we, busy, done, overflow});
    end
    checks++;
    if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000 || count !== 9'd0) begin
      errors++;
      $display("FAIL reset_values: got addr=%0h wdata=%0h count=%0d expected 0/0/0",
               mem_addr, mem_wdata, count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
  endtask

  task automatic test_encode(input bit shift_form);
    int unsigned base, want, n_wr, n_done;
    bit          got_done;
    base = shift_form ? 32'h20 : 32'h10;
    want = shift_form ? 32'h28B9 : 32'h4D5E;
    n_wr = 0; n_done = 0; got_done = 0;
    pulse_start(8'(base));
    mem_ready = 1'b1;
    if (shift_form) set_tuple(0, 4'b1010, 1, 3, 0, 1, 9, 1);
    else            set_tuple(1, 4'b0011, 2, 5, 7, 0, 0, 1);
    for (int i = 0; i < 20 && !got_done; i++) begin
      tick();
      if (t_hs) bus.in_valid = 1'b0;
      if (t_wr) begin
        checks++;
        if (t_wa !== base || t_wd !== want) begin
          errors++;
          $display("FAIL encode_write(shift=%0d): got addr=%0h data=%0h expected addr=%0h data=%0h",
                   shift_form, t_wa, t_wd, base, want);
        end
        n_wr++;
      end
      checks++;
      if (done !== m_done) begin
        errors++;
        $display("FAIL encode_done_pulse: got %b expected %b at cycle %0d", done, m_done, cyc);
      end
      if (done) got_done = 1;
    end
    checks++;
    if (!got_done || n_wr != 1 || count !== 9'd1) begin
      errors++;
      $display("FAIL encode_summary: got done=%0d writes=%0d count=%0d expected 1/1/1",
               got_done, n_wr, count);
    end
    if (!shift_form) begin
      // start landing on the DONE cycle must be ignored
      base_addr = 8'h99;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || mem_addr !== 8'h11 || count !== 9'd1) begin
        errors++;
        $display("FAIL start_in_done: got busy=%b addr=%0h count=%0d expected 0/11/1",
                 busy, mem_addr, count);
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned accepted, n_wr;
    logic [ADDR_W-1:0] hold_a;
    logic [15:0]       hold_d;
    bit got_done;
    accepted = 0; n_wr = 0; got_done = 0;
    pulse_start(8'h30);
    mem_ready = 1'b0;
    set_tuple_random(0);
    for (int i = 0; i < 20 && accepted < 4; i++) begin
      tick();
      if (t_hs) begin
        accepted++;
        set_tuple_random(accepted == 4);
      end
    end
    checks++;
    if (accepted != 4 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got accepted=%0d in_ready=%b expected 4/0", accepted, bus.in_ready);
    end
    hold_a = mem_addr;
    hold_d = mem_wdata;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (t_hs || mem_addr !== 8'h30 || mem_wdata !== 16'(exp_q[0]) ||
          mem_addr !== hold_a || mem_wdata !== hold_d) begin
        errors++;
        $display("FAIL bp_stall: got hs=%0d addr=%0h data=%0h expected hs=0 addr=30 data=%0h",
                 t_hs, mem_addr, mem_wdata, exp_q[0]);
      end
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 30 && !got_done; i++) begin
      tick();
      if (t_hs) bus.in_valid = 1'b0;
      if (t_wr) begin
        checks++;
        if (t_wa !== 32'h30 + n_wr || t_wd !== e_wd) begin
          errors++;
          $display("FAIL bp_write%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   n_wr, t_wa, t_wd, 32'h30 + n_wr, e_wd);
        end
        n_wr++;
      end
      checks++;
      if (done !== m_done) begin
        errors++;
        $display("FAIL bp_done: got %b expected %b", done, m_done);
      end
      if (done) got_done = 1;
    end
    checks++;
    if (!got_done || n_wr != 5 || count !== 9'd5) begin
      errors++;
      $display("FAIL bp_summary: got done=%0d writes=%0d count=%0d expected 1/5/5",
               got_done, n_wr, count);
    end
  endtask

  task automatic test_wrap();
    int unsigned wrap_addr [3];
    int unsigned sent, n_wr;
    bit got_done;
    wrap_addr = '{32'hFE, 32'hFF, 32'h00};
    sent = 0; n_wr = 0; got_done = 0;
    pulse_start(8'hFE);
    mem_ready = 1'b1;
    set_tuple_random(0);
    for (int i = 0; i < 30 && !got_done; i++) begin
      tick();
      if (t_hs) begin
        sent++;
        if (sent == 3) bus.in_valid = 1'b0;
        else           set_tuple_random(sent == 2);
      end
      if (t_wr) begin
        checks++;
        if (n_wr > 2 || t_wa !== wrap_addr[n_wr % 3] || t_wd !== e_wd) begin
          errors++;
          $display("FAIL wrap_write%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   n_wr, t_wa, t_wd, wrap_addr[n_wr % 3], e_wd);
        end
        n_wr++;
      end
      checks++;
      if (overflow !== m_ovf || done !== m_done) begin
        errors++;
        $display("FAIL wrap_flags: got ovf=%b done=%b expected ovf=%b done=%b",
                 overflow, done, m_ovf, m_done);
      end
      if (done) got_done = 1;
    end
    checks++;
    if (!got_done || n_wr != 3 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL wrap_summary: got done=%0d writes=%0d ovf=%b expected 1/3/1",
               got_done, n_wr, overflow);
    end
    pulse_start(8'h00);
    checks++;
    if (overflow !== 1'b0 || count !== 9'd0) begin
      errors++;
      $display("FAIL wrap_clear: got ovf=%b count=%0d expected 0/0", overflow, count);
    end
  endtask

  task automatic test_restart_reset();
    int unsigned accepted, n_wr;
    bit got_done;
    accepted = 0; n_wr = 0; got_done = 0;
    pulse_start(8'h50);
    mem_ready = 1'b0;
    set_tuple_random(0);
    for (int i = 0; i < 20 && accepted < 3; i++) begin
      tick();
      if (t_hs) begin
        accepted++;
        if (accepted == 3) bus.in_valid = 1'b0;
        else               set_tuple_random(accepted == 2);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b1 || mem_we !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_state: got busy=%b we=%b ready=%b expected 1/1/0",
               busy, mem_we, bus.in_ready);
    end
    base_addr = 8'h40;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 8'h40 || count !== 9'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart: got we=%b addr=%0h count=%0d ready=%b expected 0/40/0/1",
               mem_we, mem_addr, count, bus.in_ready);
    end
    set_tuple_random(1);
    mem_ready = 1'b1;
    for (int i = 0; i < 20 && !got_done; i++) begin
      tick();
      if (t_hs) bus.in_valid = 1'b0;
      if (t_wr) begin
        checks++;
        if (t_wa !== 32'h40 || t_wd !== e_wd) begin
          errors++;
          $display("FAIL restart_write: got addr=%0h data=%0h expected addr=40 data=%0h",
                   t_wa, t_wd, e_wd);
        end
        n_wr++;
      end
      if (done) got_done = 1;
    end
    checks++;
    if (!got_done || n_wr != 1 || count !== 9'd1) begin
      errors++;
      $display("FAIL restart_summary: got done=%0d writes=%0d count=%0d expected 1/1/1",
               got_done, n_wr, count);
    end
    pulse_start(8'h60);
    mem_ready = 1'b0;
    accepted = 0;
    set_tuple_random(0);
    for (int i = 0; i < 20 && accepted < 2; i++) begin
      tick();
      if (t_hs) begin
        accepted++;
        if (accepted == 2) bus.in_valid = 1'b0;
        else               set_tuple_random(0);
      end
    end
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h60) begin
      errors++;
      $display("FAIL stall_before_reset: got we=%b addr=%0h expected 1/60", mem_we, mem_addr);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, busy, done, overflow, bus.in_ready} !== 5'b0 || mem_addr !== 8'h00 ||
        mem_wdata !== 16'h0000 || count !== 9'd0) begin
      errors++;
      $display("FAIL async_reset: got we=%b busy=%b done=%b ovf=%b ready=%b addr=%0h data=%0h count=%0d expected all 0",
               mem_we, busy, done, overflow, bus.in_ready, mem_addr, mem_wdata, count);
    end
    model_init();
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_we !== 1'b0 || t_wr) begin
        errors++;
        $display("FAIL post_reset_write: got we=%b expected 0", mem_we);
      end
    end
  endtask

  task automatic test_back_to_back(input int unsigned n, input logic [ADDR_W-1:0] base);
    int unsigned sent, n_wr, first_wr, last_wr, done_cyc, exp_cnt;
    bit got_done;
    sent = 0; n_wr = 0; first_wr = 0; last_wr = 0; done_cyc = 0; got_done = 0;
    pulse_start(base);
    mem_ready = 1'b1;
    set_tuple_random(n == 1);
    for (int i = 0; i < int'(n) + 20 && !got_done; i++) begin
      tick();
      if (t_hs) begin
        sent++;
        if (sent == n) bus.in_valid = 1'b0;
        else           set_tuple_random(sent == n - 1);
      end
      if (t_wr) begin
        checks++;
        if (t_wa !== e_wa || t_wd !== e_wd) begin
          errors++;
          $display("FAIL b2b_write%0d: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   n_wr, t_wa, t_wd, e_wa, e_wd);
        end
        if (n_wr == 0) first_wr = cyc;
        last_wr = cyc;
        n_wr++;
      end
      checks++;
      if (done !== m_done || overflow !== m_ovf) begin
        errors++;
        $display("FAIL b2b_flags: got done=%b ovf=%b expected done=%b ovf=%b",
                 done, overflow, m_done, m_ovf);
      end
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
      end
    end
    exp_cnt = (n < COUNT_MAX) ? n : COUNT_MAX;
    checks++;
    if (n_wr != n || last_wr - first_wr != n - 1) begin
      errors++;
      $display("FAIL b2b_no_bubbles(n=%0d): got writes=%0d span=%0d expected %0d/%0d",
               n, n_wr, last_wr - first_wr, n, n - 1);
    end
    checks++;
    if (!got_done || done_cyc != last_wr + 1) begin
      errors++;
      $display("FAIL b2b_done_timing(n=%0d): got done=%0d at %0d expected at %0d",
               n, got_done, done_cyc, last_wr + 1);
    end
    checks++;
    if (count !== exp_cnt[ADDR_W:0]) begin
      errors++;
      $display("FAIL b2b_count(n=%0d): got %0d expected %0d", n, count, exp_cnt);
    end
  endtask

  task automatic test_random();
    int unsigned len, sent;
    bit got_done;
    for (int p = 0; p < 3; p++) begin
      pulse_start(8'($urandom));
      len = $urandom_range(20, 6);
      sent = 0;
      got_done = 0;
      for (int i = 0; i < 400 && !got_done; i++) begin
        mem_ready = ($urandom % 3) != 0;
        if (!bus.in_valid && sent < len && ($urandom % 4) != 0) set_tuple_random(sent == len - 1);
        checks++;
        if (bus.in_ready !== (m_running && exp_q.size() < DEPTH) || mem_we !== (exp_q.size() > 0)) begin
          errors++;
          $display("FAIL rand_ctrl: got ready=%b we=%b expected ready=%b we=%b (occupancy %0d)",
                   bus.in_ready, mem_we, m_running && exp_q.size() < DEPTH,
                   exp_q.size() > 0, exp_q.size());
        end
        tick();
        if (t_hs) begin
          sent++;
          bus.in_valid = 1'b0;
        end
        if (t_wr) begin
          checks++;
          if (t_wa !== e_wa || t_wd !== e_wd) begin
            errors++;
            $display("FAIL rand_write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                     t_wa, t_wd, e_wa, e_wd);
          end
        end
        checks++;
        if (done !== m_done || count !== m_count[ADDR_W:0] || overflow !== m_ovf) begin
          errors++;
          $display("FAIL rand_status: got done=%b count=%0d ovf=%b expected done=%b count=%0d ovf=%b",
                   done, count, overflow, m_done, m_count, m_ovf);
        end
        if (done) got_done = 1;
      end
      checks++;
      if (!got_done) begin
        errors++;
        $display("FAIL rand_timeout: got no done expected done within budget (program %0d)", p);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_init();
    test_reset();
    test_encode(1'b0);
    test_encode(1'b1);
    test_backpressure();
    test_wrap();
    test_restart_reset();
    test_back_to_back(16, 8'h80);
    test_back_to_back(520, 8'h00);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Inverse of the pipeline's instruction decode stage. Accepts decoded instruction fields over a valid/ready handshake and packs each into the 16-bit raw instruction format.
- Buffers encoded words in a small FIFO, then streams them into instruction memory at consecutive addresses through a stallable write port.
- Used by the boot/program loader and by test harnesses to build programs in instruction memory.

Parameters:
- ADDR_W, 8, instruction memory address width
- FIFO_DEPTH, 4, encoded-word buffer entries (power of two, minimum 2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; loads base_addr, clears count/overflow, enters RUN
- base_addr  in  ADDR_W  first write address, sampled on start
- in_valid  in  1  field tuple valid
- in_ready  out  1  encoder can accept a tuple
- in_last  in  1  tuple is final instruction of program
- condition  in  2  condition code
- op_code  in  4  opcode
- dest_reg  in  3  destination register
- source_reg_one  in  3  source register 1
- source_reg_two  in  3  source register 2 (non-shift form)
- is_shift  in  1  select shift form for bits [3:0]
- bits_to_shift  in  4  shift amount (shift form)
- mem_we  out  1  write request
- mem_ready  in  1  memory accepts write this cycle
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  16  encoded instruction
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last word is written
- count  out  ADDR_W+1  words written since start
- overflow  out  1  sticky; address wrapped past 2^ADDR_W-1

Behaviour:
- Encoding: [15:14]=condition, [13:10]=op_code, [9:7]=dest_reg, [6:4]=source_reg_one.
  - Non-shift form: [3:1]=source_reg_two, [0]=0.
  - Shift form: [3:0]=bits_to_shift.
  - Purely combinational into the FIFO write data; every tuple is encodable, no field checking.
- Reset (async, rst_n=0): state=IDLE; FIFO empty; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, count=0, overflow=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN. Tuples are not accepted.
  - RUN: in_ready = !fifo_full. Accepting a tuple with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0. FIFO empty and no write pending -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- start in RUN or DRAIN restarts the sequence:
  - FIFO flushed, pending words discarded.
  - base_addr reloaded, count and overflow cleared, state -> RUN.
- start in DONE is ignored; the done pulse still completes.
- Handshake: a tuple transfers on the rising edge where in_valid && in_ready.
  - Encoded word enters the FIFO at that edge.
  - Earliest mem_we for that word is the next cycle (1-cycle latency).
  - No bypass when the FIFO is full.
- Write port:
  - mem_we = FIFO non-empty; mem_wdata = FIFO head; mem_addr = current address.
  - A write completes on an edge with mem_we && mem_ready: pop FIFO, mem_addr += 1, count += 1.
  - mem_addr/mem_wdata are held stable while mem_we=1 && mem_ready=0.
- Simultaneous push and pop is allowed when the FIFO is neither empty nor full. Occupancy is unchanged.
- Wrap-around: a completed write at address 2^ADDR_W-1 sets mem_addr to 0 and sets overflow. overflow stays set until start or reset. Writes continue after the wrap.
- count saturates at 2^(ADDR_W+1)-1.
- Reset mid-operation discards all buffered words. No partial write is issued after reset deasserts.

Decomposition:
- Shared package instr_pkg holds:
  - Field offsets and widths: COND_MSB=15, OP_MSB=13, DEST_MSB=9, SRC1_MSB=6, SRC2_MSB=3, SHIFT_W=4, INSTR_W=16.
  - FSM state encoding.
  - These are the same constants the decode stage uses.
- One natural sub-module: instr_fifo, a synchronous FIFO.
  - Parameterised width/depth with push, pop, flush, full, empty, and head data.
  - FSM, encoding, and address/count logic stay in the top level.

Test Plan:
- Non-shift encode: start, base_addr=8'h10; tuple cond=01, op=0011, dest=2, src1=5, src2=7, in_last=1; mem_ready=1 -> one write mem_addr=8'h10, mem_wdata=16'h4D5E; done pulses; count=1.
- Shift encode: tuple cond=00, op=1010, dest=1, src1=3, is_shift=1, shift=9 -> mem_wdata=16'h28B9.
- Backpressure: mem_ready=0, push 5 tuples -> in_ready=0 after 4 accepted, mem_addr/mem_wdata stable. Release mem_ready -> 5 writes in order to consecutive addresses, count=5.
- Wrap: base_addr=8'hFE, 3 tuples -> writes at FE, FF, 00. overflow=1 after the FF write; cleared by the next start.
- Restart and reset: mid-DRAIN, start with base_addr=8'h40 -> FIFO flushed, next write at 8'h40, count restarts at 0. Then assert rst_n=0 during a stalled write -> mem_we=0 immediately, all outputs at reset values.
- Back-to-back: in_valid held high, mem_ready=1 for 16 tuples -> one write per cycle after the 1-cycle latency, no bubbles, done exactly one cycle after the 16th write.
